// File: rtl/fpd_pkg.sv
// Shared types and constants for the sequential single-precision divider.
// Operand format: {sign, exp[7:0], man[22:0]} plus an external hidden bit.
package fpd_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned BIAS     = 127;
    localparam int unsigned QUO_BITS = 26;
    localparam int unsigned CNT_W    = 5;

    localparam logic [EXP_W-1:0] INF_EXP = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_t;

endpackage

// File: rtl/fpd_mant_div.sv
// Iterative restoring mantissa divider: one quotient bit per step, MSB first.
// The quotient has QUO_BITS bits; rem holds twice the partial remainder after each step.
module fpd_mant_div
    import fpd_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic [MAN_W-1:0]    man_a,
    input  logic [MAN_W-1:0]    man_b,
    output logic [QUO_BITS-1:0] quo,
    output logic [MAN_W+1:0]    rem,
    output logic                done_iter
);

    logic [MAN_W:0]   div_q;
    logic [CNT_W-1:0] cnt;
    logic [MAN_W+1:0] div_ext;
    logic [MAN_W+1:0] rem_sub;
    logic             q_bit;

    always_comb begin
        div_ext   = {1'b0, div_q};
        q_bit     = (rem >= div_ext);
        rem_sub   = q_bit ? (rem - div_ext) : rem;
        done_iter = (cnt == CNT_W'(QUO_BITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            div_q <= '0;
            quo   <= '0;
            cnt   <= '0;
        end else if (load) begin
            rem   <= {2'b01, man_a};
            div_q <= {1'b1, man_b};
            quo   <= '0;
            cnt   <= '0;
        end else if (step) begin
            // rem_sub < divisor here, so the left shift never loses a set bit
            rem <= rem_sub << 1;
            quo <= {quo[QUO_BITS-2:0], q_bit};
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fpd_seq.sv
// Sequential single-precision divider with start/done handshake, fixed 28-cycle latency.
// Define FPD_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fpd_seq
    import fpd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] in1,
    input  logic        additional1,
    input  logic [31:0] in2,
    input  logic        additional2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        additionalout
);

    state_t           state;
    fp_t              a_in;
    fp_t              b_in;
    logic             sign_q;
    logic [EXP_W-1:0] e1_q;
    logic [EXP_W-1:0] e2_q;
    logic             add1_q;
    logic             add2_q;

    logic                load;
    logic                step;
    logic [QUO_BITS-1:0] quo;
    logic [MAN_W+1:0]    rem;
    logic                done_iter;

    logic                q25;
    logic [MAN_W-1:0]    man_t;
    logic [MAN_W-1:0]    man_f;
    logic signed [9:0]   e_raw;
    logic signed [9:0]   e_fin;
    fp_t                 res;
    logic                res_norm;

    assign a_in = in1;
    assign b_in = in2;
    assign load = (state == IDLE) && start;
    assign step = (state == DIV);

    fpd_mant_div u_mant_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .man_a     (a_in.man),
        .man_b     (b_in.man),
        .quo       (quo),
        .rem       (rem),
        .done_iter (done_iter)
    );

    always_comb begin
        q25   = quo[QUO_BITS-1];
        man_t = q25 ? quo[QUO_BITS-2:2] : quo[QUO_BITS-3:1];
        // modulo-1024 arithmetic reinterpreted as signed covers the full e1-e2 range
        e_raw = 10'(e1_q) - 10'(e2_q) + 10'(BIAS - 1) + 10'(q25);
    end

`ifdef FPD_ROUND_EN
    logic             guard;
    logic             sticky;
    logic [MAN_W:0]   man_sum;

    always_comb begin
        guard   = q25 ? quo[1] : quo[0];
        sticky  = (q25 & quo[0]) | (|rem);
        man_sum = {1'b0, man_t} + (MAN_W + 1)'(guard & (sticky | man_t[0]));
        man_f   = man_sum[MAN_W-1:0];
        e_fin   = e_raw + 10'(man_sum[MAN_W]);
    end
`else
    logic unused_trunc;

    always_comb begin
        man_f        = man_t;
        e_fin        = e_raw;
        unused_trunc = ^{quo[0], rem};
    end
`endif

    always_comb begin
        res      = '0;
        res_norm = 1'b0;
        if (!add1_q) begin
            res = '0;
        end else if (!add2_q) begin
            res.sign = sign_q;
            res.exp  = INF_EXP;
        end else if (e_fin >= 10'sd255) begin
            res.sign = sign_q;
            res.exp  = INF_EXP;
        end else if (e_fin <= 10'sd0) begin
            res = '0;
        end else begin
            res.sign = sign_q;
            res.exp  = e_fin[EXP_W-1:0];
            res.man  = man_f;
            res_norm = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            out           <= '0;
            additionalout <= 1'b0;
            sign_q        <= 1'b0;
            e1_q          <= '0;
            e2_q          <= '0;
            add1_q        <= 1'b0;
            add2_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign_q <= a_in.sign ^ b_in.sign;
                        e1_q   <= a_in.exp;
                        e2_q   <= b_in.exp;
                        add1_q <= additional1;
                        add2_q <= additional2;
                        busy   <= 1'b1;
                        state  <= DIV;
                    end
                end
                DIV: begin
                    if (done_iter) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    out           <= res;
                    additionalout <= res_norm;
                    busy          <= 1'b0;
                    done          <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpd_seq.sv
// Directed self-checking bench for fpd_seq; expected values are hand-computed.
// Outputs are sampled on the falling clock edge.
module tb_fpd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] in1;
    logic        additional1;
    logic [31:0] in2;
    logic        additional2;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        additionalout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fpd_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in1           (in1),
        .additional1   (additional1),
        .in2           (in2),
        .additional2   (additional2),
        .busy          (busy),
        .done          (done),
        .out           (out),
        .additionalout (additionalout)
    );

    // Pulses start for one cycle, scrambles the inputs, then waits (bounded) for done.
    // lat is the number of cycles from the start cycle to the done cycle, or -1.
    task automatic do_op(input logic [31:0] a, input logic aa,
                         input logic [31:0] b, input logic ab, output int lat);
        @(negedge clk);
        in1 = a; additional1 = aa; in2 = b; additional2 = ab; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in1 = $urandom; in2 = $urandom;
        additional1 = 1'($urandom); additional2 = 1'($urandom);
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        in1 = '0; in2 = '0; additional1 = 1'b0; additional2 = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (out !== 32'h0) begin fails++; $display("FAIL reset_out got=%h exp=%h", out, 32'h0); end
        tests++; if (additionalout !== 1'b0) begin fails++; $display("FAIL reset_addout got=%b exp=0", additionalout); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        @(negedge clk);
        in1 = 32'h40C00000; additional1 = 1'b1; in2 = 32'h40000000; additional2 = 1'b1; start = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            tests++;
            if (busy !== (c <= 27)) begin
                fails++; $display("FAIL busy_c%0d got=%b exp=%b", c, busy, (c <= 27));
            end
            tests++;
            if (done !== (c == 28)) begin
                fails++; $display("FAIL done_c%0d got=%b exp=%b", c, done, (c == 28));
            end
            if (c == 28) begin
                tests++; if (out !== 32'h40400000) begin fails++; $display("FAIL six_by_two got=%h exp=%h", out, 32'h40400000); end
                tests++; if (additionalout !== 1'b1) begin fails++; $display("FAIL six_by_two_add got=%b exp=1", additionalout); end
            end
        end
        tests++; if (out !== 32'h40400000) begin fails++; $display("FAIL out_hold got=%h exp=%h", out, 32'h40400000); end
    endtask

    task automatic test_third();
        int lat;
        logic [31:0] exp_q;
`ifdef FPD_ROUND_EN
        exp_q = 32'h3EAAAAAB;
`else
        exp_q = 32'h3EAAAAAA;
`endif
        do_op(32'h3F800000, 1'b1, 32'h40400000, 1'b1, lat);
        tests++; if (lat != 28) begin fails++; $display("FAIL third_lat got=%0d exp=28", lat); end
        tests++; if (out !== exp_q) begin fails++; $display("FAIL one_third got=%h exp=%h", out, exp_q); end
        tests++; if (additionalout !== 1'b1) begin fails++; $display("FAIL one_third_add got=%b exp=1", additionalout); end
    endtask

    task automatic test_back_to_back();
        int dones;
        int lat;
        @(negedge clk);
        in1 = 32'hBF800000; additional1 = 1'b1; in2 = 32'h40000000; additional2 = 1'b1; start = 1'b1;
        dones = 0;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) begin
                in1 = 32'h40C00000; in2 = 32'h40000000; start = 1'b1;
            end
            if (done) dones++;
        end
        tests++; if (dones != 1) begin fails++; $display("FAIL b2b_done_count got=%0d exp=1", dones); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done_c28 got=%b exp=1", done); end
        tests++; if (out !== 32'hBF000000) begin fails++; $display("FAIL neg_half got=%h exp=%h", out, 32'hBF000000); end
        // new request raised in the done cycle itself
        in1 = 32'h40C00000; additional1 = 1'b1; in2 = 32'h40000000; additional2 = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        tests++; if (lat != 28) begin fails++; $display("FAIL b2b_second_lat got=%0d exp=28", lat); end
        tests++; if (out !== 32'h40400000) begin fails++; $display("FAIL b2b_second got=%h exp=%h", out, 32'h40400000); end
    endtask

    typedef struct {
        logic [31:0] a;
        logic        aa;
        logic [31:0] b;
        logic        ab;
        logic [31:0] q;
        logic        qa;
    } vec_t;

    task automatic test_special();
        vec_t vecs[11];
        int lat;
        vecs[0]  = '{32'hC0000000, 1'b1, 32'h00000000, 1'b0, 32'hFF800000, 1'b0};
        vecs[1]  = '{32'h00000000, 1'b0, 32'h40000000, 1'b1, 32'h00000000, 1'b0};
        vecs[2]  = '{32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[3]  = '{32'h7F000000, 1'b1, 32'h3E800000, 1'b1, 32'h7F800000, 1'b0};
        vecs[4]  = '{32'h00800000, 1'b1, 32'h7F000000, 1'b1, 32'h00000000, 1'b0};
        vecs[5]  = '{32'h7F000000, 1'b1, 32'h3F000000, 1'b1, 32'h7F800000, 1'b0};
        vecs[6]  = '{32'h7F000000, 1'b1, 32'h3F800000, 1'b1, 32'h7F000000, 1'b1};
        vecs[7]  = '{32'h00800000, 1'b1, 32'h3F800000, 1'b1, 32'h00800000, 1'b1};
        vecs[8]  = '{32'h00800000, 1'b1, 32'h40000000, 1'b1, 32'h00000000, 1'b0};
        vecs[9]  = '{32'h3FFFFFFF, 1'b1, 32'h3F800000, 1'b1, 32'h3FFFFFFF, 1'b1};
        vecs[10] = '{32'hFF000000, 1'b1, 32'hBF800000, 1'b1, 32'h7F000000, 1'b1};
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].a, vecs[i].aa, vecs[i].b, vecs[i].ab, lat);
            tests++;
            if (lat != 28) begin
                fails++; $display("FAIL special%0d_lat got=%0d exp=28", i, lat);
            end
            tests++;
            if (out !== vecs[i].q || additionalout !== vecs[i].qa) begin
                fails++;
                $display("FAIL special%0d got=%h/%b exp=%h/%b", i, out, additionalout, vecs[i].q, vecs[i].qa);
            end
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        int dones;
        do_op(32'h40C00000, 1'b1, 32'h40000000, 1'b1, lat);
        @(negedge clk);
        in1 = 32'h3F800000; additional1 = 1'b1; in2 = 32'h40400000; additional2 = 1'b1; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        tests++; if (out !== 32'h0) begin fails++; $display("FAIL midrst_out got=%h exp=%h", out, 32'h0); end
        tests++; if (additionalout !== 1'b0) begin fails++; $display("FAIL midrst_addout got=%b exp=0", additionalout); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL midrst_done got=%b exp=0", done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        tests++; if (dones != 0) begin fails++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
        do_op(32'h40C00000, 1'b1, 32'h40000000, 1'b1, lat);
        tests++; if (lat != 28) begin fails++; $display("FAIL midrst_after_lat got=%0d exp=28", lat); end
        tests++; if (out !== 32'h40400000) begin fails++; $display("FAIL midrst_after got=%h exp=%h", out, 32'h40400000); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_third();
        test_back_to_back();
        test_special();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
